adc_capture_ctrl: RTL
=====================

Name: adc_capture_ctrl

Overview:
- Capture sequencer for the AD9226 receive path. It sits between the decimation stage output and the AXI-Stream DMA master.
- On a start command it latches the configuration, enables the decimator and drives its decimation ratio, then waits for a trigger.
- After the trigger it forwards exactly cfg_length decimated samples as one AXI-Stream packet with TLAST, and reports status: busy, done, overflow and sample count.

Parameters:
- DATA_WIDTH, 16, width of decimated sample and of m_axis_tdata.
- REG_WIDTH, 32, width of the config/status registers (decimate ratio, length, count).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  one-cycle start pulse.
- cfg_abort  in  1  one-cycle abort pulse; has priority over cfg_start.
- cfg_decimate  in  REG_WIDTH  decimation ratio; latched at start.
- cfg_length  in  REG_WIDTH  samples per packet; latched at start; 0 is treated as 1.
- cfg_trig_mode  in  2  0 immediate, 1 rising crossing, 2 falling crossing, 3 reserved (behaves as 0).
- cfg_trig_level  in  DATA_WIDTH  trigger threshold, unsigned compare.
- dec_enable  out  1  drives the decimator's downstream-ready/enable input.
- dec_decimate  out  REG_WIDTH  latched ratio to the decimator.
- s_data  in  DATA_WIDTH  decimated sample.
- s_valid  in  1  sample strobe; no backpressure is possible upstream.
- m_axis_tdata  out  DATA_WIDTH  output sample.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tlast  out  1  last beat of the packet.
- busy  out  1  state is not IDLE and not DONE.
- done  out  1  sticky; set on the final handshake, cleared by start or reset.
- overflow  out  1  sticky; set when a sample is dropped, cleared by start or reset.
- sample_count  out  REG_WIDTH  samples accepted into the packet so far.

Behaviour:
- Reset: all outputs 0, state IDLE, latched config 0.
- States: IDLE, WAIT_TRIG, CAPTURE, DRAIN, DONE.
- IDLE or DONE + cfg_start (with cfg_abort low):
  - Next cycle: latch config, clear done, overflow and sample_count, clear prev_valid, enter WAIT_TRIG.
  - dec_enable = 1 from that cycle on.
  - cfg_start in any other state is ignored.
- WAIT_TRIG, on each s_valid:
  - Mode 0: trigger on the first valid sample.
  - Mode 1: trigger when prev_valid && prev < level && s_data >= level.
  - Mode 2: trigger when prev_valid && prev > level && s_data <= level.
  - On a non-triggering sample, store it as prev and set prev_valid.
  - The triggering sample is the first captured sample: it is loaded into the output register in the same cycle and the state moves to CAPTURE, or straight to DRAIN if length is 1.
- CAPTURE: on each s_valid the sample is loaded if the output register is empty, or is being emptied this cycle (tvalid && tready).
  - A load increments sample_count.
  - tlast = 1 when sample_count reaches length (the length-th sample).
  - Once the last sample is loaded, go to DRAIN.
- Output register: one stage, registered outputs.
  - tvalid is held with stable tdata/tlast until tready is seen (AXI-Stream rule).
  - Latency from s_valid to tvalid: 1 cycle.
- Overflow: s_valid while the register is full and not being emptied.
  - The sample is dropped, overflow is set and the count is not advanced; capture continues.
- DRAIN:
  - dec_enable = 0.
  - On the handshake of the tlast beat: done = 1, go to DONE.
  - dec_enable remains 0 in DONE and IDLE.
- Abort, in WAIT_TRIG or CAPTURE:
  - dec_enable = 0 next cycle and no further samples are accepted.
  - If a beat is pending, it is held and its tlast is forced to 1, then the state goes to IDLE after its handshake.
  - Otherwise go to IDLE directly.
  - done is not set by an abort.
- Simultaneous start and abort: abort wins; start is ignored.
- sample_count saturates at length; it never wraps.
- Reset mid-capture: everything returns to reset values in the next cycle, including tvalid = 0.

Decomposition:
- Shared package (adc_pkg): state enum encoding, trigger-mode constants (TRIG_IMM, TRIG_RISE, TRIG_FALL), default widths.
- Natural sub-module: adc_trig_detect. It holds the prev/prev_valid registers and the mode compare, and outputs a combinational trig_hit qualified by s_valid.
- FSM, counters and the output register stay in the top module.

Test Plan:
- Immediate, no stall: mode 0, length 4, decimate 0, tready = 1, samples 10,11,12,13,14 → beats 10,11,12,13 with tlast on 13; done = 1; sample 14 not forwarded; dec_enable = 0.
- Rising trigger: level 100, mode 1, input 50,90,120,130, length 2 → beats 120,130; 50 and 90 discarded; tlast on 130.
- Falling trigger with first-sample guard: level 100, first sample after start is 80 → no trigger (prev invalid); then 150,90 → triggers on 90.
- Overflow: tready low for 3 cycles during CAPTURE, s_valid every cycle, length 8 → overflow = 1, dropped samples absent, sample_count counts only forwarded beats, packet still ends with tlast.
- Abort with pending beat: tready low, abort in CAPTURE → tvalid held, tlast forced 1; after tready the state is IDLE, done = 0, dec_enable = 0.
- Start+abort in the same cycle from IDLE → stays IDLE; length 0 start → single-beat packet with tlast.

Source files
------------

// File: rtl/adc_pkg.sv
// ============================================================================
// Module   : adc_pkg
// Brief    : Shared types and constants for the AD9226 capture sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_REG_WIDTH  = 32;

   localparam logic [1:0] TRIG_IMM  = 2'd0;
   localparam logic [1:0] TRIG_RISE = 2'd1;
   localparam logic [1:0] TRIG_FALL = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TRIG = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/adc_capture_ctrl_if.sv
// ============================================================================
// Module   : adc_capture_ctrl_if
// Brief    : Sample-in / AXI-Stream-out bus of the capture sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_capture_ctrl_if
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] m_axis_tdata;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;

   // Capture controller side: consumes decimated samples, masters the stream.
   modport master (
      input  s_data,
      input  s_valid,
      input  m_axis_tready,
      output m_axis_tdata,
      output m_axis_tvalid,
      output m_axis_tlast
   );

   // Environment side: decimator producing samples, DMA accepting the stream.
   modport slave (
      output s_data,
      output s_valid,
      output m_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tvalid,
      input  m_axis_tlast
   );

endinterface

`default_nettype wire

// File: rtl/adc_trig_detect.sv
// ============================================================================
// Module   : adc_trig_detect
// Brief    : Level-crossing trigger detector with previous-sample history.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_trig_detect
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  i_clear,
   input  wire logic                  i_arm,
   input  wire logic [1:0]            i_mode,
   input  wire logic [DATA_WIDTH-1:0] i_level,
   input  wire logic [DATA_WIDTH-1:0] i_data,
   input  wire logic                  i_valid,
   output logic                       o_trig_hit
);

   logic [DATA_WIDTH-1:0] r_prev;
   logic                  r_prev_valid;
   logic                  w_cond;

   // Crossing modes need a prior sample; mode 3 falls back to immediate.
   always_comb begin
      w_cond = 1'b1;
      case (i_mode)
         TRIG_RISE: w_cond = r_prev_valid && (r_prev < i_level) && (i_data >= i_level);
         TRIG_FALL: w_cond = r_prev_valid && (r_prev > i_level) && (i_data <= i_level);
         default:   w_cond = 1'b1;
      endcase
   end

   assign o_trig_hit = i_valid && i_arm && w_cond;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
      end else if (i_valid && i_arm && !w_cond) begin
         r_prev       <= i_data;
         r_prev_valid <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
// ============================================================================
// Module   : adc_capture_ctrl
// Brief    : Triggered capture sequencer, decimator output to AXI-Stream DMA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_capture_ctrl
   import adc_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int REG_WIDTH  = DEF_REG_WIDTH
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  cfg_start,
   input  wire logic                  cfg_abort,
   input  wire logic [REG_WIDTH-1:0]  cfg_decimate,
   input  wire logic [REG_WIDTH-1:0]  cfg_length,
   input  wire logic [1:0]            cfg_trig_mode,
   input  wire logic [DATA_WIDTH-1:0] cfg_trig_level,
   output logic                       dec_enable,
   output logic [REG_WIDTH-1:0]       dec_decimate,
   adc_capture_ctrl_if.master         bus,
   output logic                       busy,
   output logic                       done,
   output logic                       overflow,
   output logic [REG_WIDTH-1:0]       sample_count
);

   state_t                r_state;
   state_t                w_next_state;

   logic [REG_WIDTH-1:0]  r_len;
   logic [REG_WIDTH-1:0]  r_decimate;
   logic [1:0]            r_mode;
   logic [DATA_WIDTH-1:0] r_level;

   logic [DATA_WIDTH-1:0] r_tdata;
   logic                  r_tvalid;
   logic                  r_tlast;
   logic [REG_WIDTH-1:0]  r_count;
   logic                  r_done;
   logic                  r_ovf;
   logic                  r_abort_pending;

   logic                  w_hs;
   logic                  w_can_load;
   logic                  w_last;
   logic                  w_trig_arm;
   logic                  w_trig_hit;
   logic                  w_start;
   logic                  w_load;
   logic                  w_ovf_set;
   logic                  w_done_set;
   logic                  w_force_last;
   logic                  w_set_abort;

   assign w_hs       = r_tvalid && bus.m_axis_tready;
   assign w_can_load = !r_tvalid || w_hs;
   assign w_last     = ((r_count + 1'b1) == r_len);
   assign w_trig_arm = (r_state == ST_WAIT_TRIG) && !cfg_abort;

   adc_trig_detect #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_trig (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_start),
      .i_arm      (w_trig_arm),
      .i_mode     (r_mode),
      .i_level    (r_level),
      .i_data     (bus.s_data),
      .i_valid    (bus.s_valid),
      .o_trig_hit (w_trig_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_load       = 1'b0;
      w_ovf_set    = 1'b0;
      w_done_set   = 1'b0;
      w_force_last = 1'b0;
      w_set_abort  = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (cfg_start && !cfg_abort) begin
               w_start      = 1'b1;
               w_next_state = ST_WAIT_TRIG;
            end
         end
         ST_WAIT_TRIG: begin
            if (cfg_abort) begin
               w_next_state = ST_IDLE;
            end else if (w_trig_hit) begin
               w_load       = 1'b1;
               w_next_state = w_last ? ST_DRAIN : ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            // An abort with a stalled beat closes the packet on that beat.
            if (cfg_abort) begin
               if (r_tvalid && !bus.m_axis_tready) begin
                  w_force_last = 1'b1;
                  w_set_abort  = 1'b1;
                  w_next_state = ST_DRAIN;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end else if (bus.s_valid) begin
               if (w_can_load) begin
                  w_load = 1'b1;
                  if (w_last) begin
                     w_next_state = ST_DRAIN;
                  end
               end else begin
                  w_ovf_set = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (w_hs && r_tlast) begin
               w_next_state = r_abort_pending ? ST_IDLE : ST_DONE;
               w_done_set   = !r_abort_pending;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_len           <= '0;
         r_decimate      <= '0;
         r_mode          <= '0;
         r_level         <= '0;
         r_count         <= '0;
         r_done          <= 1'b0;
         r_ovf           <= 1'b0;
         r_abort_pending <= 1'b0;
      end else begin
         if (w_start) begin
            r_len           <= (cfg_length == '0) ? REG_WIDTH'(1) : cfg_length;
            r_decimate      <= cfg_decimate;
            r_mode          <= cfg_trig_mode;
            r_level         <= cfg_trig_level;
            r_count         <= '0;
            r_done          <= 1'b0;
            r_ovf           <= 1'b0;
            r_abort_pending <= 1'b0;
         end else begin
            if (w_load && (r_count != r_len)) begin
               r_count <= r_count + 1'b1;
            end
            if (w_ovf_set) begin
               r_ovf <= 1'b1;
            end
            if (w_done_set) begin
               r_done <= 1'b1;
            end
            if (w_set_abort) begin
               r_abort_pending <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end else if (w_load) begin
         r_tdata  <= bus.s_data;
         r_tvalid <= 1'b1;
         r_tlast  <= w_last;
      end else if (w_force_last) begin
         r_tlast  <= 1'b1;
      end else if (w_hs) begin
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
      end
   end

   assign bus.m_axis_tdata  = r_tdata;
   assign bus.m_axis_tvalid = r_tvalid;
   assign bus.m_axis_tlast  = r_tlast;

   assign dec_enable   = (r_state == ST_WAIT_TRIG) || (r_state == ST_CAPTURE);
   assign busy         = (r_state == ST_WAIT_TRIG) || (r_state == ST_CAPTURE) ||
                         (r_state == ST_DRAIN);
   assign dec_decimate = r_decimate;
   assign done         = r_done;
   assign overflow     = r_ovf;
   assign sample_count = r_count;

endmodule

`default_nettype wire
